backprop_stack: RTL and testbench



---
 rtl/backprop_stack.sv | 83 ++++++++
 tb/tb_backprop_stack.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/backprop_stack.sv
// Per-layer gradient vector stack: seed (copy) or chain from the layer above, with a registered dC/dW read port.
// Optional macro BACKPROP_STACK_SATURATE_EN: chained lane results saturate instead of wrapping.
module backprop_stack #(
    parameter int data_size      = 4,
    parameter int size           = 3,
    parameter int max_layer_size = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [data_size*size-1:0]   backprop_to_all,
    input  logic [data_size*size-1:0]   backprop_dense,
    input  logic [data_size*size-1:0]   backprop_start,
    input  logic [32:0]                 current_layer_index,
    input  logic [32:0]                 dc_dw_layer_index,
    input  logic                        copy,
    input  logic                        cal_dy_dy_old,
    output logic [data_size*size-1:0]   dc_dw_stream
);
    localparam int vec_w  = data_size * size;
    localparam int addr_w = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
    localparam int full_w = 2 * data_size + 1;

    logic [vec_w-1:0]  stack_reg [max_layer_size];
    logic [vec_w-1:0]  dc_dw_stream_reg;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              is_top;
    logic [addr_w-1:0] wr_addr;
    logic [addr_w-1:0] up_addr;
    logic [addr_w-1:0] rd_addr;
    logic [vec_w-1:0]  up_vec;
    logic [vec_w-1:0]  cal_vec;

    // Range checks use the full unsigned index; only then do the low bits select an entry.
    assign wr_in_range = (current_layer_index < 33'(max_layer_size));
    assign rd_in_range = (dc_dw_layer_index < 33'(max_layer_size));
    assign is_top      = (current_layer_index == 33'(max_layer_size - 1));
    assign wr_addr     = current_layer_index[addr_w-1:0];
    assign rd_addr     = dc_dw_layer_index[addr_w-1:0];
    assign up_addr     = wr_addr + addr_w'(1);
    assign up_vec      = is_top ? backprop_start : stack_reg[up_addr];

    for (genvar gi = 0; gi < size; gi++) begin : g_lane
        logic [data_size-1:0] up_lane;
        logic [data_size-1:0] dense_lane;
        logic [data_size-1:0] add_lane;
        logic [full_w-1:0]    full_res;

        assign up_lane    = up_vec[(size-gi)*data_size-1 -: data_size];
        assign dense_lane = backprop_dense[(size-gi)*data_size-1 -: data_size];
        assign add_lane   = backprop_to_all[(size-gi)*data_size-1 -: data_size];
        assign full_res   = full_w'(up_lane) * full_w'(dense_lane) + full_w'(add_lane);
`ifdef BACKPROP_STACK_SATURATE_EN
        assign cal_vec[(size-gi)*data_size-1 -: data_size] =
            (full_res > full_w'({data_size{1'b1}})) ? {data_size{1'b1}} : full_res[data_size-1:0];
`else
        assign cal_vec[(size-gi)*data_size-1 -: data_size] = full_res[data_size-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < max_layer_size; i++) begin
                stack_reg[i] <= '0;
            end
            dc_dw_stream_reg <= '0;
        end else begin
            if (wr_in_range) begin
                if (copy) begin
                    stack_reg[wr_addr] <= backprop_start;
                end else if (cal_dy_dy_old) begin
                    stack_reg[wr_addr] <= cal_vec;
                end
            end
            // Samples pre-edge contents, so a same-index write shows up one edge later.
            dc_dw_stream_reg <= rd_in_range ? stack_reg[rd_addr] : '0;
        end
    end

    assign dc_dw_stream = dc_dw_stream_reg;

endmodule

// File: tb/tb_backprop_stack.sv
// Bench for backprop_stack: directed plan steps then random traffic against a lane-level array model.
module tb_backprop_stack;
    localparam int DS   = 4;
    localparam int SZ   = 3;
    localparam int ML   = 4;
    localparam int VW   = DS * SZ;
    localparam int LMAX = (1 << DS) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] backprop_to_all = '0;
    logic [VW-1:0] backprop_dense = '0;
    logic [VW-1:0] backprop_start = '0;
    logic [32:0]   current_layer_index = '0;
    logic [32:0]   dc_dw_layer_index = '0;
    logic          copy = 1'b0;
    logic          cal_dy_dy_old = 1'b0;
    logic [VW-1:0] dc_dw_stream;

    int checks = 0;
    int failures = 0;
    int model [ML][SZ];

    backprop_stack #(.data_size(DS), .size(SZ), .max_layer_size(ML)) dut (
        .clk                 (clk),
        .reset               (reset),
        .backprop_to_all     (backprop_to_all),
        .backprop_dense      (backprop_dense),
        .backprop_start      (backprop_start),
        .current_layer_index (current_layer_index),
        .dc_dw_layer_index   (dc_dw_layer_index),
        .copy                (copy),
        .cal_dy_dy_old       (cal_dy_dy_old),
        .dc_dw_stream        (dc_dw_stream)
    );

    always #5 clk = ~clk;

    // Lane 0 sits at the most significant end of a vector.
    function automatic int lane_of(logic [VW-1:0] v, int i);
        return int'((v >> ((SZ - 1 - i) * DS)) & VW'(LMAX));
    endfunction

    function automatic logic [VW-1:0] pack_entry(int e);
        logic [VW-1:0] v = '0;
        for (int i = 0; i < SZ; i++) v = (v << DS) | VW'(model[e][i]);
        return v;
    endfunction

    function automatic int chain_lane(int u, int d, int a);
        int r = u * d + a;
`ifdef BACKPROP_STACK_SATURATE_EN
        return (r > LMAX) ? LMAX : r;
`else
        return r % (LMAX + 1);
`endif
    endfunction

    // One clock: drive inputs, advance the model, check the read port after the edge.
    // fixed >= 0 additionally compares against a hand-derived constant.
    task automatic step(input bit rst, input bit cp, input bit cal,
                        input logic [32:0] cur, input logic [32:0] rd,
                        input logic [VW-1:0] st, input logic [VW-1:0] dn,
                        input logic [VW-1:0] ta, input int fixed, input string tag);
        logic [VW-1:0] exp_rd;
        int up [SZ];
        int c;
        reset = rst; copy = cp; cal_dy_dy_old = cal;
        current_layer_index = cur; dc_dw_layer_index = rd;
        backprop_start = st; backprop_dense = dn; backprop_to_all = ta;

        exp_rd = (!rst && rd < ML) ? pack_entry(int'(rd)) : '0;
        if (rst) begin
            for (int e = 0; e < ML; e++) for (int i = 0; i < SZ; i++) model[e][i] = 0;
        end else if (cur < ML) begin
            c = int'(cur);
            if (cp) begin
                for (int i = 0; i < SZ; i++) model[c][i] = lane_of(st, i);
            end else if (cal) begin
                for (int i = 0; i < SZ; i++) up[i] = (c == ML - 1) ? lane_of(st, i) : model[c + 1][i];
                for (int i = 0; i < SZ; i++) model[c][i] = chain_lane(up[i], lane_of(dn, i), lane_of(ta, i));
            end
        end

        @(posedge clk);
        #1;
        $display("txn %s rst=%0b cp=%0b cal=%0b cur=%0d rd=%0d stream=%h", tag, rst, cp, cal, cur, rd, dc_dw_stream);
        checks++;
        assert (dc_dw_stream === exp_rd) else begin
            failures++;
            $error("FAIL %s model: got %h expected %h", tag, dc_dw_stream, exp_rd);
        end
        if (fixed >= 0) begin
            checks++;
            assert (dc_dw_stream === VW'(fixed)) else begin
                failures++;
                $error("FAIL %s const: got %h expected %h", tag, dc_dw_stream, VW'(fixed));
            end
        end
    endtask

    initial begin
        logic [32:0] rcur, rrd;
        for (int e = 0; e < ML; e++) for (int i = 0; i < SZ; i++) model[e][i] = 0;

        step(1, 0, 0, 0, 0, '0, '0, '0, 0, "reset_init");
        // Plan 1: fill, reset, read every entry back as zero
        for (int e = 0; e < ML; e++) step(0, 1, 0, 33'(e), 0, VW'($urandom), '0, '0, -1, "fill");
        step(1, 1, 1, 1, 1, 12'hFFF, 12'h111, 12'h111, 0, "reset_pulse");
        for (int e = 0; e < ML; e++) step(0, 0, 0, 0, 33'(e), '0, '0, '0, 0, "reset_read");
        // Plan 2: copy then read
        step(0, 1, 0, 2, 0, 12'h123, '0, '0, -1, "copy2");
        step(0, 0, 0, 0, 2, '0, '0, '0, 'h123, "read_copy2");
        // Plan 3: chain from entry 2
        step(0, 0, 1, 1, 2, '0, 12'h222, 12'h101, 'h123, "chain1");
        step(0, 0, 0, 0, 1, '0, '0, '0, 'h347, "read_chain1");
        // Plan 4: top layer chains from the start vector
        step(0, 0, 1, 3, 1, 12'h234, 12'h310, 12'h005, -1, "top3");
        step(0, 0, 0, 0, 3, '0, '0, '0, 'h635, "read_top3");
        // Plan 5: lane overflow
        step(0, 1, 0, 2, 0, 12'hFFF, '0, '0, -1, "copy_fff");
        step(0, 0, 1, 1, 0, '0, 12'h222, 12'h333, -1, "chain_ovf");
`ifdef BACKPROP_STACK_SATURATE_EN
        step(0, 0, 0, 0, 1, '0, '0, '0, 'hFFF, "read_ovf");
`else
        step(0, 0, 0, 0, 1, '0, '0, '0, 'h111, "read_ovf");
`endif
        // Plan 6: copy wins over cal, out-of-range writes and reads
        step(0, 1, 1, 0, 0, 12'hABC, 12'h555, 12'h555, -1, "copy_and_cal");
        step(0, 0, 0, 0, 0, '0, '0, '0, 'hABC, "read_prio");
        step(0, 1, 0, 5, 0, 12'h777, '0, '0, -1, "wr_oob5");
        step(0, 0, 1, 33'h1_0000_0001, 0, 12'h777, 12'h111, 12'h111, -1, "wr_oob_high");
        for (int e = 0; e < ML; e++) step(0, 0, 0, 0, 33'(e), '0, '0, '0, -1, "read_after_oob");
        step(0, 0, 0, 0, 7, '0, '0, '0, 0, "read_oob7");
        step(0, 0, 0, 0, 33'h1_0000_0002, '0, '0, '0, 0, "read_oob_high");

        // Random traffic, including same-index read/write and occasional resets
        for (int n = 0; n < 300; n++) begin
            rcur = ($urandom_range(0, 9) == 0) ? 33'h1_0000_0000 | 33'($urandom_range(0, 3)) : 33'($urandom_range(0, 5));
            rrd  = 33'($urandom_range(0, 5));
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 rcur, rrd, VW'($urandom), VW'($urandom), VW'($urandom), -1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
